// File: rtl/iter_muldiv.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) sharing one shift datapath.
// Optional MULDIV_DIV0_FAST_EN: a divide by zero skips the iteration and adds the div0_o flag.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
`ifdef MULDIV_DIV0_FAST_EN
  ,
  output logic             div0_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             sign_p;
  logic             sign_r;

  logic             sa, sb, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_sh, div_tr;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi, div_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign sa     = signed_i & opa_i[WIDTH-1];
  assign sb     = signed_i & opb_i[WIDTH-1];
  assign mag_a  = sa ? (WIDTH'(0) - opa_i) : opa_i;
  assign mag_b  = sb ? (WIDTH'(0) - opb_i) : opb_i;
  assign accept = ((state == S_IDLE) || (state == S_DONE)) & start_i & ~annul_i;

  // Multiply: conditional add into the upper half, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Divide: remainder < divisor keeps the trial difference within WIDTH+1 bits, so bit WIDTH is the borrow.
  assign div_sh = {acc_hi, acc_lo[WIDTH-1]};
  assign div_tr = div_sh - {1'b0, opnd};
  assign div_ok = ~div_tr[WIDTH];
  assign div_hi = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo = {acc_lo[WIDTH-2:0], div_ok};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = sign_p ? ((2*WIDTH)'(0) - prod) : prod;
  assign q_fix    = sign_p ? (WIDTH'(0) - acc_lo) : acc_lo;
  assign r_fix    = sign_r ? (WIDTH'(0) - acc_hi) : acc_hi;

  assign busy_o  = (state == S_CALC) || (state == S_FIX);
  assign ready_o = (state == S_DONE);

`ifdef MULDIV_DIV0_FAST_EN
  logic fast_div0;
  assign fast_div0 = accept & op_div_i & (opb_i == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      sign_p <= 1'b0;
      sign_r <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
`ifdef MULDIV_DIV0_FAST_EN
      div0_o <= 1'b0;
`endif
    end else begin
`ifdef MULDIV_DIV0_FAST_EN
      div0_o <= 1'b0;
`endif
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            cnt    <= CW'(WIDTH);
            is_div <= op_div_i;
            sign_p <= sa ^ sb;
            sign_r <= sa;
            opnd   <= op_div_i ? mag_b : mag_a;
            acc_hi <= '0;
            acc_lo <= op_div_i ? mag_a : mag_b;
            state  <= S_CALC;
`ifdef MULDIV_DIV0_FAST_EN
            if (fast_div0) begin
              // Same values the slow path would produce: quotient all ones, remainder |opa|, sign-fixed.
              hi_o   <= sa ? (WIDTH'(0) - mag_a) : mag_a;
              lo_o   <= (sa ^ sb) ? WIDTH'(1) : {WIDTH{1'b1}};
              div0_o <= 1'b1;
              cnt    <= '0;
              state  <= S_DONE;
            end
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= is_div ? div_hi : mul_hi;
            acc_lo <= is_div ? div_lo : mul_lo;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            hi_o  <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_o  <= is_div ? q_fix : prod_fix[WIDTH-1:0];
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Randomized scoreboard bench for iter_muldiv: driver pushes reference results, monitor checks on ready_o.
module tb_iter_muldiv;
  localparam int W = 32;

  logic         clk, rst, start, op_div, sgn, annul;
  logic [W-1:0] opa, opb, hi, lo;
  logic         busy, ready;
`ifdef MULDIV_DIV0_FAST_EN
  logic         div0;
  localparam bit FAST = 1'b1;
`else
  logic         div0;
  localparam bit FAST = 1'b0;
  assign div0 = 1'b0;
`endif

  iter_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_div_i(op_div), .signed_i(sgn),
    .annul_i(annul), .opa_i(opa), .opb_i(opb), .busy_o(busy), .ready_o(ready),
    .hi_o(hi), .lo_o(lo)
`ifdef MULDIV_DIV0_FAST_EN
    , .div0_o(div0)
`endif
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
    int           bz;
    logic         d0;
  } exp_t;

  exp_t         q[$];
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operand values.
  task automatic ref_model(input bit dv, input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa64, sb64, qq, rr;
    logic [63:0] p;
    sa64 = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb64 = sg ? longint'($signed(b)) : longint'({32'b0, b});
    if (!dv) begin
      p = 64'(sa64 * sb64);
      h = p[63:32];
      l = p[31:0];
    end else if (b == '0) begin
      h = a;
      l = (sg && a[W-1]) ? 32'h1 : 32'hFFFF_FFFF;
    end else begin
      qq = sa64 / sb64;
      rr = sa64 % sb64;
      h = rr[31:0];
      l = qq[31:0];
    end
  endtask

  // Called just after a rising edge; start is sampled at the following edge.
  task automatic issue(input bit dv, input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit fast;
    fast = FAST && dv && (b == '0);
    ref_model(dv, sg, a, b, e.hi, e.lo);
    e.cyc = cyc + (fast ? 1 : W + 2);
    e.bz  = fast ? 0 : W + 1;
    e.d0  = fast;
    q.push_back(e);
    start = 1'b1; op_div = dv; sgn = sg; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !busy) return;
    end
    n_chk++; n_err++;
    $display("FAIL timeout: %0d results outstanding, busy=%b", q.size(), busy);
    q.delete();
  endtask

  task automatic run(input bit dv, input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(dv, sg, a, b);
    wait_idle();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: compares every ready_o pulse against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ready) begin
          if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_ready: got ready=1 required 0 at cycle %0d", cyc);
          end else begin
            e = q.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("ready_cycle", 64'(cyc), 64'(e.cyc));
            chk("busy_cycles", 64'(busy_cnt), 64'(e.bz));
            if (FAST) chk("div0", 64'(div0), 64'(e.d0));
            last_hi = e.hi;
            last_lo = e.lo;
          end
        end
        if (start && !annul) busy_cnt = 0;
        if (busy) busy_cnt++;
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    bit dv, sg;
    rst = 1'b1; start = 1'b0; op_div = 1'b0; sgn = 1'b0; annul = 1'b0; opa = '0; opb = '0;
    #12;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ready", 64'(ready), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(1'b0, 1'b1, -32'sd3, 32'd5);
    run(1'b1, 1'b1, -32'sd7, 32'd2);
    run(1'b1, 1'b1, 32'd7, -32'sd2);
    run(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b1, 1'b0, 32'd7, 32'd0);
    run(1'b1, 1'b1, -32'sd7, 32'd0);

    // Annul mid-divide: no ready, outputs keep the previous result.
    issue(1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1 annul = 1'b0;
    void'(q.pop_back());
    repeat (3) @(posedge clk); #1;
    chk("annul_busy", 64'(busy), 64'(0));
    chk("annul_hold_hi", 64'(hi), 64'(last_hi));
    chk("annul_hold_lo", 64'(lo), 64'(last_lo));
    run(1'b0, 1'b0, 32'd6, 32'd7);
    chk("mul6x7_lo", 64'(lo), 64'h2A);

    // Start blocked by annul in IDLE.
    start = 1'b1; annul = 1'b1; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #1 start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
    chk("blocked_start_busy", 64'(busy), 64'(0));

    // Back-to-back: second start lands in the DONE cycle.
    issue(1'b0, 1'b1, 32'd12345, -32'sd678);
    repeat (W + 1) @(posedge clk);
    #1 issue(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd77);
    wait_idle();

    // Asynchronous reset in the middle of CALC.
    issue(1'b0, 1'b0, 32'd99, 32'd99);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(ready), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    q.delete();
    last_hi = '0; last_lo = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run(1'b1, 1'b1, -32'sd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      dv = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      issue(dv, sg, a, b);
      if ($urandom_range(0, 2) == 0) begin
        repeat ((FAST && dv && b == '0) ? 0 : W + 1) @(posedge clk);
        #1 issue(1'b0, 1'b1, W'($urandom), W'($urandom));
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/iter_muldiv.md
# iter_muldiv

Parametrised iterative multiply/divide unit for the EX stage. It executes one signed or unsigned multiply or divide per request and returns a 2×WIDTH result as HI/LO halves. Requests use a start/ready handshake with annul support. It replaces the fixed 32-bit divider and the separate multiplier with one shared shift datapath, and its stall and result contract is identical for both operation types.

## Interface
- WIDTH, 32, operand width in bits; legal values are even and ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; sampled only in IDLE or DONE.
- op_div_i  in  1  0 = multiply, 1 = divide; sampled with start_i.
- signed_i  in  1  1 = two's-complement operands; sampled with start_i.
- annul_i  in  1  abort the operation in flight.
- opa_i  in  WIDTH  multiplicand or dividend; sampled with start_i.
- opb_i  in  WIDTH  multiplier or divisor; sampled with start_i.
- busy_o  out  1  high in CALC and FIX; EX stall source.
- ready_o  out  1  single-cycle pulse in DONE.
- hi_o  out  WIDTH  multiply: product[2W-1:W]; divide: remainder.
- lo_o  out  WIDTH  multiply: product[W-1:0]; divide: quotient.
- div0_o  out  1  present only with `MULDIV_DIV0_FAST_EN`; high in DONE when the divisor was 0.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Accept:** in IDLE or DONE, `start_i & ~annul_i` → CALC.
  - The magnitudes of opa/opb are latched. They equal the raw values if unsigned.
  - Result signs are latched:
    - multiply: sa^sb.
    - quotient: sa^sb.
    - remainder: sa (sign of the dividend).
  - The iteration counter is loaded with WIDTH.
- **CALC:** one iteration per cycle; counter decrements; at 0 → FIX.
  - Multiply: shift-add, 2W accumulator.
  - Divide: restoring. Each step shifts {rem, quo} left by 1, trial-subtracts the divisor, and sets the quotient bit if no borrow.
- **FIX:** applies two's-complement negation per the latched signs, then writes hi_o/lo_o; → DONE.
- **DONE:** ready_o=1 for exactly one cycle.
  - Next state is CALC if a new start is accepted, else IDLE.
- **Result hold:** hi_o/lo_o hold their value from FIX until the next FIX. They never change during CALC.
- **Divide-by-zero:** no trap.
  - The result is lo = all-ones magnitude, hi = |opa|, then sign fix as usual.
  - Unsigned 7/0 gives lo=FFFFFFFF, hi=00000007.
- **Overflow:** signed MIN / −1 gives lo = MIN (wraps) and hi = 0. No flag is raised.
- **Annul:**
  - In CALC or FIX, annul_i → IDLE at the next edge.
  - No ready_o pulse is produced, and hi_o/lo_o keep their previous values.
  - annul_i is ignored in IDLE/DONE except that it blocks start_i that cycle.
- **Reset:** asynchronous, at any time, including mid-operation.
  - State → IDLE; counter → 0.
  - hi_o=0, lo_o=0, ready_o=0, busy_o=0, div0_o=0.

## Timing
- Start is sampled at edge E0; busy_o is high from after E0 to after E(W+1).
- ready_o is high during the cycle after E(W+1). Latency is WIDTH+2 cycles, which is 34 for WIDTH=32.
- hi_o/lo_o are valid in that same cycle, and remain stable afterwards.
- Back-to-back: a start in the DONE cycle re-enters CALC, so there is 0 idle cycles between operations. Throughput is one operation per W+2 cycles.
- busy_o is registered, not decoded from start_i. The EX stage must add its own combinational stall for the start cycle.

## Configuration
- **Macro:** `MULDIV_DIV0_FAST_EN`.
- **Defined:**
  - A divide with opb_i==0 skips CALC/FIX: start → DONE directly, latency 1 cycle.
  - hi_o/lo_o are written with the same values as the slow path (hi = sign-fixed |opa|, lo per the divide-by-zero rule).
  - div0_o=1 for that DONE cycle. The div0_o port exists.
- **Undefined:**
  - Divide-by-zero takes the full W+2 cycles.
  - The div0_o port is absent.

## Test plan
- **Unsigned multiply:** WIDTH=32, FFFFFFFF×FFFFFFFF → ready_o at cycle 34, hi=FFFFFFFE, lo=00000001; busy_o high for exactly 33 cycles.
- **Signed:**
  - mul −3×5 → hi=FFFFFFFF, lo=FFFFFFF1.
  - div −7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
  - div 7/−2 → lo=FFFFFFFD, hi=00000001.
- **Corners:**
  - WIDTH=8 signed 0x80/0xFF → lo=0x80, hi=0x00.
  - Unsigned 7/0 → lo=0xFF, hi=0x07.
  - With `MULDIV_DIV0_FAST_EN` defined: same values, ready_o at cycle 1, div0_o=1.
- **Annul:**
  - annul_i pulsed at cycle 10 of a divide → IDLE, no ready_o, hi/lo still hold the prior result.
  - A new mul 6×7 then returns lo=0000002A at +34.
- **Back-to-back:** start asserted in the DONE cycle → second result ready_o exactly 34 cycles after the first, both results correct.
- **Reset mid-operation:** rst asserted asynchronously mid-CALC → immediate busy_o=0, ready_o=0, hi=lo=0. After release a fresh operation completes normally.
